bf_loop_ctrl: RTL and testbench

Loop sequencer for the bf interpreter core; it implements opcodes 6 '[' and 7 ']', which the core treats as no-ops.
- Watches the opcode at the current pc together with the current cell value.
- Redirects the core's pc through a hardware return stack.
- Scans forward over zero-valued loops while holding the core.
- Sits beside the core, sharing the program ROM address (pc) and cell read data (i_din).

---
 rtl/bf_loop_ctrl.sv | 172 +++++++++++++++++
 tb/tb_bf_loop_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_loop_ctrl.sv
// bf_loop_ctrl: '[' / ']' sequencer for the bf core, with a pc return stack and forward scan.
// Optional feature macro BF_LOOP_STATS_EN adds iter_cnt and max_depth outputs.
module bf_loop_ctrl #(
  parameter int unsigned PCW   = 16,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [PCW-1:0]               pc,
  input  logic [3:0]                   i_prg,
  input  logic [DW-1:0]                i_din,
  output logic                         pc_load,
  output logic [PCW-1:0]               pc_value,
  output logic                         busy,
  output logic                         err,
  output logic [1:0]                   err_code,
  output logic [$clog2(DEPTH+1)-1:0]   depth
`ifdef BF_LOOP_STATS_EN
  ,
  output logic [31:0]                  iter_cnt,
  output logic [$clog2(DEPTH+1)-1:0]   max_depth
`endif
);

  localparam int unsigned DCW = $clog2(DEPTH + 1);
  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [3:0] OP_OPEN  = 4'd6;
  localparam logic [3:0] OP_CLOSE = 4'd7;
  localparam logic [3:0] OP_HALT  = 4'd15;

  localparam logic [1:0] ERR_OVF   = 2'd1;
  localparam logic [1:0] ERR_EMPTY = 2'd2;
  localparam logic [1:0] ERR_UNMAT = 2'd3;

  typedef enum logic [1:0] {ST_RUN, ST_SKIP, ST_HALT} state_t;

  state_t         state, state_nxt;
  logic [PCW-1:0] stk [DEPTH];
  logic [PCW-1:0] scan, scan_nxt;
  logic [PCW-1:0] pc_inc, top;
  logic [DCW-1:0] depth_nxt;
  logic           push, pop, err_set;
  logic [1:0]     err_code_nxt;
  logic           empty, full, din_nz;

  assign pc_inc    = pc + PCW'(1);
  assign empty     = (depth == '0);
  assign full      = (depth == DCW'(DEPTH));
  assign din_nz    = |i_din;
  assign top       = stk[AW'(depth - DCW'(1))];
  assign depth_nxt = depth + DCW'(push) - DCW'(pop);

  // Next state and the combinational pc redirect; error cycles hold pc where it is.
  always_comb begin
    state_nxt    = state;
    scan_nxt     = scan;
    pc_load      = 1'b0;
    pc_value     = pc_inc;
    busy         = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    err_set      = 1'b0;
    err_code_nxt = 2'd0;
    case (state)
      ST_RUN: begin
        case (i_prg)
          OP_OPEN: begin
            pc_load = 1'b1;
            if (!din_nz) begin
              busy      = 1'b1;
              scan_nxt  = PCW'(1);
              state_nxt = ST_SKIP;
            end else if (full) begin
              busy         = 1'b1;
              pc_value     = pc;
              err_set      = 1'b1;
              err_code_nxt = ERR_OVF;
              state_nxt    = ST_HALT;
            end else begin
              push = 1'b1;
            end
          end
          OP_CLOSE: begin
            pc_load = 1'b1;
            if (empty) begin
              busy         = 1'b1;
              pc_value     = pc;
              err_set      = 1'b1;
              err_code_nxt = ERR_EMPTY;
              state_nxt    = ST_HALT;
            end else if (din_nz) begin
              pc_value = top;
            end else begin
              pop = 1'b1;
            end
          end
          default: ;
        endcase
      end
      ST_SKIP: begin
        busy    = 1'b1;
        pc_load = 1'b1;
        case (i_prg)
          OP_OPEN: scan_nxt = scan + PCW'(1);
          OP_CLOSE: begin
            if (scan == PCW'(1)) begin
              scan_nxt  = '0;
              state_nxt = ST_RUN;
            end else begin
              scan_nxt = scan - PCW'(1);
            end
          end
          OP_HALT: begin
            pc_value     = pc;
            err_set      = 1'b1;
            err_code_nxt = ERR_UNMAT;
            state_nxt    = ST_HALT;
          end
          default: ;
        endcase
      end
      ST_HALT: busy = 1'b1;
      default: state_nxt = ST_HALT;
    endcase
    if (reset) begin
      pc_load = 1'b0;
      busy    = 1'b0;
    end
  end

  // Control state; the first error latches until reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_RUN;
      depth    <= '0;
      scan     <= '0;
      err      <= 1'b0;
      err_code <= 2'd0;
    end else begin
      state <= state_nxt;
      depth <= depth_nxt;
      scan  <= scan_nxt;
      if (err_set && !err) begin
        err      <= 1'b1;
        err_code <= err_code_nxt;
      end
    end
  end

  // Return stack storage; contents are don't-care above depth.
  always_ff @(posedge clock) begin
    if (!reset && push) stk[AW'(depth)] <= pc_inc;
  end

`ifdef BF_LOOP_STATS_EN
  logic loop_back;
  assign loop_back = (state == ST_RUN) && (i_prg == OP_CLOSE) && din_nz && !empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      iter_cnt  <= '0;
      max_depth <= '0;
    end else begin
      if (loop_back && (iter_cnt != '1)) iter_cnt <= iter_cnt + 32'd1;
      if (depth_nxt > max_depth) max_depth <= depth_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_bf_loop_ctrl.sv
// tb_bf_loop_ctrl: directed bf programs on a tiny bench core plus randomized opcode streams,
// every cycle compared against a behavioural stack/scan model.
`timescale 1ns/1ps
module tb_bf_loop_ctrl;
  localparam int unsigned PCW   = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned DCW   = $clog2(DEPTH + 1);
  localparam int          PC_MOD = 1 << PCW;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [PCW-1:0] pc = '0;
  logic [3:0]     i_prg = 4'd0;
  logic [DW-1:0]  i_din = '0;
  logic           pc_load, busy, err;
  logic [PCW-1:0] pc_value;
  logic [1:0]     err_code;
  logic [DCW-1:0] depth;
`ifdef BF_LOOP_STATS_EN
  logic [31:0]    iter_cnt;
  logic [DCW-1:0] max_depth;
`endif

  always #5 clock = ~clock;

  bf_loop_ctrl #(.PCW(PCW), .DEPTH(DEPTH), .DW(DW)) dut (
    .clock    (clock),
    .reset    (reset),
    .pc       (pc),
    .i_prg    (i_prg),
    .i_din    (i_din),
    .pc_load  (pc_load),
    .pc_value (pc_value),
    .busy     (busy),
    .err      (err),
    .err_code (err_code),
    .depth    (depth)
`ifdef BF_LOOP_STATS_EN
    ,
    .iter_cnt (iter_cnt),
    .max_depth(max_depth)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: loop return addresses as a queue, scan nesting as an int.
  int     m_stack[$];
  bit     m_skip = 0, m_halt = 0, m_err = 0;
  int     m_scan = 0, m_code = 0, m_maxd = 0;
  longint m_iter = 0;
  bit     e_load = 0, e_busy = 0;
  int     e_value = 0;
  bit     armed = 0;
  int     pcv, op, din, nxt;

  task automatic raise(input int code);
    if (!m_err) begin
      m_err  = 1;
      m_code = code;
    end
    m_halt = 1;
  endtask

  always @(posedge clock) if (reset) armed <= 1'b1;

  always @(negedge clock) begin
    if (armed) begin
      pcv = int'(pc);
      op  = int'(i_prg);
      din = int'(i_din);
      nxt = (pcv + 1) % PC_MOD;
      check("err", longint'(err), longint'(m_err));
      check("err_code", longint'(err_code), longint'(m_code));
      check("depth", longint'(depth), longint'(m_stack.size()));
`ifdef BF_LOOP_STATS_EN
      check("iter_cnt", longint'(iter_cnt), m_iter);
      check("max_depth", longint'(max_depth), longint'(m_maxd));
`endif
      e_load  = 0;
      e_busy  = 0;
      e_value = nxt;
      if (reset) begin
        m_stack.delete();
        m_skip = 0; m_halt = 0; m_err = 0;
        m_scan = 0; m_code = 0; m_maxd = 0; m_iter = 0;
      end else if (m_halt) begin
        e_busy = 1;
      end else if (m_skip) begin
        e_busy = 1;
        e_load = 1;
        if (op == 6) m_scan++;
        else if (op == 7) begin
          if (m_scan == 1) m_skip = 0;
          else m_scan--;
        end else if (op == 15) begin
          e_value = pcv;
          raise(3);
        end
      end else if (op == 6) begin
        e_load = 1;
        if (din == 0) begin
          e_busy = 1;
          m_skip = 1;
          m_scan = 1;
        end else if (m_stack.size() == DEPTH) begin
          e_busy  = 1;
          e_value = pcv;
          raise(1);
        end else begin
          m_stack.push_back(nxt);
        end
      end else if (op == 7) begin
        e_load = 1;
        if (m_stack.size() == 0) begin
          e_busy  = 1;
          e_value = pcv;
          raise(2);
        end else if (din != 0) begin
          e_value = m_stack[$];
          if (m_iter < 64'hFFFF_FFFF) m_iter++;
        end else begin
          void'(m_stack.pop_back());
        end
      end
      if (!reset && m_stack.size() > m_maxd) m_maxd = m_stack.size();
      check("pc_load", longint'(pc_load), longint'(e_load));
      check("busy", longint'(busy), longint'(e_busy));
      if (e_load) check("pc_value", longint'(pc_value), longint'(e_value));
    end
  end

  // Tiny bench core: '+' '-' '>' '<' on an 8-cell tape, 'H' halts, past the end reads as halt.
  string prog;
  int    cells[8];
  int    ptr, cpc;

  function automatic int op_of(input byte c);
    case (c)
      "+": return 0;
      "-": return 1;
      ">": return 2;
      "<": return 3;
      ".": return 4;
      ",": return 5;
      "[": return 6;
      "]": return 7;
      default: return 15;
    endcase
  endfunction

  function automatic int cur_op();
    if (cpc < prog.len()) return op_of(prog[cpc]);
    return 15;
  endfunction

  task automatic drive_core();
    pc    = PCW'(cpc);
    i_prg = 4'(cur_op());
    i_din = DW'(cells[ptr]);
  endtask

  task automatic step_core();
    int o;
    o = cur_op();
    if (e_load) cpc = e_value;
    else if (!e_busy && o != 15) begin
      case (o)
        0: cells[ptr] = (cells[ptr] + 1) % 256;
        1: cells[ptr] = (cells[ptr] + 255) % 256;
        2: ptr = (ptr + 1) % 8;
        3: ptr = (ptr + 7) % 8;
        default: ;
      endcase
      cpc = (cpc + 1) % PC_MOD;
    end
  endtask

  task automatic load_prog(input string p, input int c0);
    prog = p;
    foreach (cells[i]) cells[i] = 0;
    cells[0] = c0;
    ptr = 0;
    cpc = 0;
    reset = 1'b1;
    drive_core();
    @(posedge clock);
    #1;
    reset = 1'b0;
    drive_core();
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      step_core();
      drive_core();
    end
  endtask

  initial begin
    // "++[-]": one loop-back to pc 3, then pop; pc 5 after seven cycles.
    load_prog("++[-]", 0);
    check("t1_reset_depth", longint'(depth), 0);
    check("t1_reset_err", longint'(err), 0);
    run(7);
    check("t1_pc", cpc, 5);
    check("t1_depth", longint'(depth), 0);
    check("t1_cell", cells[0], 0);
`ifdef BF_LOOP_STATS_EN
    check("t1_iter", longint'(iter_cnt), 1);
    check("t1_maxd", longint'(max_depth), 1);
`endif

    // Zero-cell '[' at pc 0 scans six cycles to pc 6 without executing anything.
    load_prog("[[+]>].", 0);
    run(6);
    #1;
    check("t2_pc", cpc, 6);
    check("t2_busy", longint'(busy), 0);
    check("t2_ptr", ptr, 0);
    check("t2_cell", cells[0], 0);

    // Fifth nested push overflows a 4-deep stack and freezes pc.
    load_prog("+[[[[[", 0);
    run(6);
    check("t3_err", longint'(err), 1);
    check("t3_code", longint'(err_code), 1);
    check("t3_depth", longint'(depth), 4);
    run(5);
    #1;
    check("t3_pc", cpc, 5);
    check("t3_busy", longint'(busy), 1);

    // ']' on empty stack, then HALT holds for 100 cycles.
    load_prog("]", 0);
    run(1);
    check("t4_code", longint'(err_code), 2);
    run(100);
    #1;
    check("t4_code_hold", longint'(err_code), 2);
    check("t4_busy", longint'(busy), 1);
    check("t4_load", longint'(pc_load), 0);

    // Unmatched '[' runs into halt opcode at pc 9.
    load_prog("[++++++++H", 0);
    run(10);
    check("t5_code", longint'(err_code), 3);

    // Reset in the third SKIP cycle with one loop still on the stack.
    load_prog("+[>[+]<].", 0);
    run(5);
    check("t6_pre_depth", longint'(depth), 1);
    reset = 1'b1;
    #1;
    check("t6_rst_busy", longint'(busy), 0);
    check("t6_rst_load", longint'(pc_load), 0);
    @(posedge clock);
    #1;
    check("t6_depth", longint'(depth), 0);
    check("t6_err", longint'(err), 0);
`ifdef BF_LOOP_STATS_EN
    check("t6_iter", longint'(iter_cnt), 0);
`endif
    reset = 1'b0;
    prog = "+.";
    foreach (cells[i]) cells[i] = 0;
    ptr = 0;
    cpc = 0;
    drive_core();
    #1;
    check("t6_busy", longint'(busy), 0);
    run(2);

    // Open-loop random opcode streams; the model checks every cycle.
    for (int n = 0; n < 4000; n++) begin
      int r;
      @(posedge clock);
      #1;
      if (m_halt) reset = ($urandom_range(0, 7) == 0);
      else reset = ($urandom_range(0, 299) == 0);
      pc = ($urandom_range(0, 15) == 0) ? '1 : PCW'($urandom);
      r = $urandom_range(0, 99);
      if (r < 35) i_prg = 4'd6;
      else if (r < 65) i_prg = (m_stack.size() == 0 && !m_skip && $urandom_range(0, 9) != 0) ? 4'd6 : 4'd7;
      else if (r < 67) i_prg = 4'd15;
      else i_prg = 4'($urandom_range(0, 14));
      i_din = ($urandom_range(0, 9) < 4) ? '0 : DW'($urandom_range(1, 255));
    end
    @(posedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
